// File: rtl/alarm_ring_controller.sv
// Alarm ringing life-cycle: trigger on a rising match edge, ring with a blinking LED,
// snooze with countdown, stop/timeout, and no re-ring within the same matching minute.
module alarm_ring_controller #(
    parameter int BLINK_CYCLES   = 25_000_000,
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       match,
    input  logic       alarm_en,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       alarm_led,
    output logic       ringing,
    output logic       snoozing,
    output logic [8:0] snooze_left,
    output logic [1:0] snooze_count,
    output logic [1:0] fsm_state
);

    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state, state_n;
    logic          match_d;
    logic          trig_q;
    logic [7:0]    ring_timer, ring_timer_n;
    logic [BW-1:0] blink_cnt, blink_cnt_n;
    logic          alarm_led_n;
    logic [8:0]    snooze_left_n;
    logic [1:0]    snooze_count_n;
    logic          quit;

    // The edge detect is registered so ringing rises two cycles after match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_d <= 1'b1;
            trig_q  <= 1'b0;
        end else begin
            match_d <= match;
            trig_q  <= match & ~match_d & alarm_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ring_timer   <= '0;
            blink_cnt    <= '0;
            alarm_led    <= 1'b0;
            snooze_left  <= '0;
            snooze_count <= '0;
        end else begin
            state        <= state_n;
            ring_timer   <= ring_timer_n;
            blink_cnt    <= blink_cnt_n;
            alarm_led    <= alarm_led_n;
            snooze_left  <= snooze_left_n;
            snooze_count <= snooze_count_n;
        end
    end

    assign quit = stop_btn | ~alarm_en;

    always_comb begin
        state_n        = state;
        ring_timer_n   = ring_timer;
        blink_cnt_n    = blink_cnt;
        alarm_led_n    = 1'b0;
        snooze_left_n  = snooze_left;
        snooze_count_n = snooze_count;
        unique case (state)
            IDLE: begin
                ring_timer_n   = '0;
                blink_cnt_n    = '0;
                snooze_left_n  = '0;
                snooze_count_n = '0;
                if (trig_q) begin
                    state_n     = RING;
                    alarm_led_n = 1'b1;
                end
            end
            RING: begin
                if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
                    blink_cnt_n = '0;
                    alarm_led_n = ~alarm_led;
                end else begin
                    blink_cnt_n = blink_cnt + BW'(1);
                    alarm_led_n = alarm_led;
                end
                // Stop beats snooze; snooze beats a coincident timeout tick.
                if (quit) begin
                    state_n     = DONE;
                    alarm_led_n = 1'b0;
                end else if (snooze_btn && (int'(snooze_count) < MAX_SNOOZE)) begin
                    state_n        = SNOOZE;
                    alarm_led_n    = 1'b0;
                    snooze_left_n  = 9'(SNOOZE_SECONDS);
                    snooze_count_n = snooze_count + 2'd1;
                end else if (sec_tick) begin
                    if (ring_timer == 8'(RING_SECONDS - 1)) begin
                        state_n     = DONE;
                        alarm_led_n = 1'b0;
                    end else begin
                        ring_timer_n = ring_timer + 8'd1;
                    end
                end
            end
            SNOOZE: begin
                if (quit) begin
                    state_n       = DONE;
                    snooze_left_n = '0;
                end else if (sec_tick) begin
                    if (snooze_left == 9'd1) begin
                        state_n       = RING;
                        snooze_left_n = '0;
                        ring_timer_n  = '0;
                        blink_cnt_n   = '0;
                        alarm_led_n   = 1'b1;
                    end else begin
                        snooze_left_n = snooze_left - 9'd1;
                    end
                end
            end
            DONE: begin
                snooze_left_n = '0;
                if (!match) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign ringing   = (state == RING);
    assign snoozing  = (state == SNOOZE);
    assign fsm_state = state;

endmodule

// File: tb/tb_alarm_ring_controller.sv
// Directed bench for alarm_ring_controller with small timing parameters and
// hand-computed expectations checked by immediate assertions.
module tb_alarm_ring_controller;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RING   = 2'd1;
    localparam logic [1:0] S_SNOOZE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic       sec_tick, match, alarm_en, snooze_btn, stop_btn;
    logic       alarm_led, ringing, snoozing;
    logic [8:0] snooze_left;
    logic [1:0] snooze_count;
    logic [1:0] fsm_state;

    int checks = 0;
    int errors = 0;

    alarm_ring_controller #(
        .BLINK_CYCLES(4),
        .RING_SECONDS(5),
        .SNOOZE_SECONDS(3),
        .MAX_SNOOZE(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sec_tick(sec_tick),
        .match(match),
        .alarm_en(alarm_en),
        .snooze_btn(snooze_btn),
        .stop_btn(stop_btn),
        .alarm_led(alarm_led),
        .ringing(ringing),
        .snoozing(snoozing),
        .snooze_left(snooze_left),
        .snooze_count(snooze_count),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Inputs change on the falling edge, so each pulse spans exactly one rising edge.
    task automatic pulse(input logic tk, input logic sn, input logic sp);
        sec_tick   = tk;
        snooze_btn = sn;
        stop_btn   = sp;
        @(negedge clk);
        sec_tick   = 1'b0;
        snooze_btn = 1'b0;
        stop_btn   = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) pulse(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; match = 1'b0; alarm_en = 1'b1;
        sec_tick = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
        cyc(2);
        chk("rst_ringing", 32'(ringing), 0);
        chk("rst_led", 32'(alarm_led), 0);
        chk("rst_snoozing", 32'(snoozing), 0);
        chk("rst_left", 32'(snooze_left), 0);
        chk("rst_count", 32'(snooze_count), 0);
        chk("rst_state", 32'(fsm_state), 32'(S_IDLE));
        rst = 1'b0;
        cyc(2);

        // Trigger, blink and timeout
        match = 1'b1;
        cyc(1);
        chk("trig_lat1", 32'(ringing), 0);
        cyc(1);
        chk("trig_lat2", 32'(ringing), 1);
        chk("led_on_entry", 32'(alarm_led), 1);
        cyc(3);
        chk("led_still_on", 32'(alarm_led), 1);
        cyc(1);
        chk("led_toggle_off", 32'(alarm_led), 0);
        cyc(4);
        chk("led_toggle_on", 32'(alarm_led), 1);
        ticks(4);
        chk("ring_before_timeout", 32'(ringing), 1);
        ticks(1);
        chk("timeout_ringing", 32'(ringing), 0);
        chk("timeout_led", 32'(alarm_led), 0);
        chk("timeout_state", 32'(fsm_state), 32'(S_DONE));
        cyc(2);
        chk("done_hold", 32'(fsm_state), 32'(S_DONE));
        match = 1'b0;
        cyc(1);
        chk("done_to_idle", 32'(fsm_state), 32'(S_IDLE));

        // Snooze cycles up to the limit
        match = 1'b1;
        cyc(2);
        chk("ring2", 32'(ringing), 1);
        pulse(1'b0, 1'b1, 1'b0);
        chk("snz1_snoozing", 32'(snoozing), 1);
        chk("snz1_ringing", 32'(ringing), 0);
        chk("snz1_left", 32'(snooze_left), 3);
        chk("snz1_count", 32'(snooze_count), 1);
        chk("snz1_led", 32'(alarm_led), 0);
        ticks(1);
        chk("snz_left2", 32'(snooze_left), 2);
        ticks(1);
        chk("snz_left1", 32'(snooze_left), 1);
        ticks(1);
        chk("snz_rering", 32'(ringing), 1);
        chk("snz_rering_left", 32'(snooze_left), 0);
        chk("snz_rering_count", 32'(snooze_count), 1);
        chk("snz_rering_led", 32'(alarm_led), 1);
        ticks(4);
        chk("fresh_timer", 32'(ringing), 1);
        pulse(1'b0, 1'b1, 1'b0);
        chk("snz2_count", 32'(snooze_count), 2);
        chk("snz2_snoozing", 32'(snoozing), 1);
        ticks(3);
        chk("snz2_rering", 32'(ringing), 1);
        pulse(1'b0, 1'b1, 1'b0);
        chk("snz3_ignored_ring", 32'(ringing), 1);
        chk("snz3_ignored_snz", 32'(snoozing), 0);
        chk("snz3_ignored_count", 32'(snooze_count), 2);

        // Stop and no re-trigger within the same minute
        pulse(1'b0, 1'b0, 1'b1);
        chk("stop_ringing", 32'(ringing), 0);
        chk("stop_state", 32'(fsm_state), 32'(S_DONE));
        ticks(10);
        chk("no_retrig_ring", 32'(ringing), 0);
        chk("no_retrig_state", 32'(fsm_state), 32'(S_DONE));
        match = 1'b0;
        cyc(1);
        match = 1'b1;
        cyc(2);
        chk("retrig", 32'(ringing), 1);
        chk("retrig_count", 32'(snooze_count), 0);

        // Stop and snooze together: stop wins
        pulse(1'b0, 1'b1, 1'b1);
        chk("both_state", 32'(fsm_state), 32'(S_DONE));
        chk("both_count", 32'(snooze_count), 0);
        chk("both_snoozing", 32'(snoozing), 0);
        match = 1'b0;
        cyc(1);

        // Disarm during snooze, coincident with a tick
        match = 1'b1;
        cyc(2);
        chk("ring4", 32'(ringing), 1);
        pulse(1'b0, 1'b1, 1'b0);
        ticks(1);
        chk("dis_left2", 32'(snooze_left), 2);
        alarm_en = 1'b0;
        ticks(1);
        chk("dis_snoozing", 32'(snoozing), 0);
        chk("dis_left", 32'(snooze_left), 0);
        chk("dis_state", 32'(fsm_state), 32'(S_DONE));
        match = 1'b0;
        cyc(1);
        chk("dis_idle", 32'(fsm_state), 32'(S_IDLE));
        match = 1'b1;
        cyc(3);
        chk("dis_no_ring", 32'(ringing), 0);
        chk("dis_no_ring_state", 32'(fsm_state), 32'(S_IDLE));
        match = 1'b0;
        alarm_en = 1'b1;
        cyc(1);

        // Snooze and the timeout tick together: snooze wins
        match = 1'b1;
        cyc(2);
        ticks(4);
        chk("pre_timeout", 32'(ringing), 1);
        pulse(1'b1, 1'b1, 1'b0);
        chk("snz_vs_to_snz", 32'(snoozing), 1);
        chk("snz_vs_to_count", 32'(snooze_count), 1);
        pulse(1'b0, 1'b0, 1'b1);
        chk("snz_stop_left", 32'(snooze_left), 0);
        chk("snz_stop_state", 32'(fsm_state), 32'(S_DONE));
        match = 1'b0;
        cyc(1);

        // Async reset mid-ring, released with match still high
        match = 1'b1;
        cyc(2);
        chk("ring6", 32'(ringing), 1);
        chk("ring6_led", 32'(alarm_led), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_ringing", 32'(ringing), 0);
        chk("async_led", 32'(alarm_led), 0);
        chk("async_state", 32'(fsm_state), 32'(S_IDLE));
        @(negedge clk);
        rst = 1'b0;
        cyc(4);
        chk("post_rst_no_ring", 32'(ringing), 0);
        match = 1'b0;
        cyc(1);
        match = 1'b1;
        cyc(2);
        chk("post_rst_retrig", 32'(ringing), 1);
        match = 1'b0;
        cyc(2);
        chk("match_fall_keeps_ring", 32'(ringing), 1);
        pulse(1'b0, 1'b0, 1'b1);
        cyc(1);
        chk("final_idle", 32'(fsm_state), 32'(S_IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_ring_controller.md
Name: alarm_ring_controller

Overview:
- Sits directly downstream of the alarm-match comparator. It takes the compare result and the 1 Hz time base, and owns the alarm's ringing life-cycle.
- The ringing life-cycle covers arm/trigger, ring timeout, snooze with countdown, stop, and no re-trigger within the matching minute.
- It drives the blinking alarm LED and exposes ring/snooze status and the snooze countdown to the display path.

Parameters:
- BLINK_CYCLES, 25_000_000: clk cycles per LED half-period (2 Hz blink at 100 MHz).
- RING_SECONDS, 60: seconds of ringing before auto-stop; range 1..255.
- SNOOZE_SECONDS, 300: snooze length in seconds; range 1..511.
- MAX_SNOOZE, 3: snoozes allowed per alarm event; range 0..3.

Ports:
- clk, in, 1: system clock (100 MHz).
- rst, in, 1: asynchronous, active-high reset.
- sec_tick, in, 1: one-clk-cycle strobe, once per counted second (5x in fast-forward).
- match, in, 1: level; high while current hh:mm equals the alarm setting.
- alarm_en, in, 1: alarm armed (alarm-off switch inverted); low disarms.
- snooze_btn, in, 1: debounced single-cycle pulse.
- stop_btn, in, 1: debounced single-cycle pulse.
- alarm_led, out, 1: blinking indicator while ringing.
- ringing, out, 1: high in RING.
- snoozing, out, 1: high in SNOOZE.
- snooze_left, out, 9: seconds remaining in snooze; 0 outside SNOOZE.
- snooze_count, out, 2: snoozes used in the current alarm event.

Behaviour:
- All state is registered on the rising edge of clk. rst asynchronously forces:
  - state=IDLE
  - all outputs 0
  - internal timers 0
  - match_d=1, so a match already high at reset release does not trigger.
- match_d is a one-cycle delayed copy of match. trig = match & ~match_d & alarm_en.
- States: IDLE, RING, SNOOZE, DONE.
- IDLE:
  - trig -> RING next cycle.
  - On entry: ring_timer=0, snooze_count=0, blink_cnt=0, alarm_led=1.
- RING (priority high to low):
  - (a) stop_btn or ~alarm_en -> DONE.
  - (b) snooze_btn with snooze_count<MAX_SNOOZE -> SNOOZE. Load snooze_left=SNOOZE_SECONDS and increment snooze_count. snooze_btn when the limit is reached is ignored.
  - (c) sec_tick with ring_timer==RING_SECONDS-1 -> DONE (timeout).
  - (d) sec_tick otherwise: ring_timer+1.
- SNOOZE:
  - stop_btn or ~alarm_en -> DONE.
  - sec_tick with snooze_left==1 -> RING. Reload ring_timer=0, blink_cnt=0, alarm_led=1. snooze_count is unchanged.
  - sec_tick otherwise: snooze_left-1.
  - snooze_btn is ignored.
  - match is ignored; the snooze countdown survives the minute rollover.
- DONE:
  - match==0 -> IDLE.
  - Otherwise hold, so the same minute never re-rings after stop or timeout.
- alarm_led:
  - In RING only, blink_cnt counts clk cycles 0..BLINK_CYCLES-1. At the terminal count it wraps to 0 and alarm_led toggles.
  - alarm_led is 0 in every other state, within one cycle of state exit.
- Latency:
  - Status outputs are registered and change the cycle after the causing input.
  - ringing rises 2 cycles after match rises: edge detect plus state register.
- snooze_left and snooze_count are registered.
- snooze_left is forced to 0 on any exit from SNOOZE.
- Simultaneous events:
  - stop_btn and snooze_btn together in RING: stop wins.
  - snooze_btn and a timeout tick together: snooze wins.
  - ~alarm_en and sec_tick together in SNOOZE: DONE.
- Reset mid-ring or mid-snooze returns to IDLE with outputs 0. If match is still high, no re-trigger occurs until match falls and rises again.
- match falling while in RING does not stop ringing; only stop, disarm or timeout end it.

Test Plan:
Sim parameters: BLINK_CYCLES=4, RING_SECONDS=5, SNOOZE_SECONDS=3, MAX_SNOOZE=2.
- Trigger and timeout: raise match with alarm_en=1 -> ringing=1 after 2 cycles. alarm_led toggles every 4 clk. After 5 sec_ticks: ringing=0, alarm_led=0, state DONE. Drop match -> IDLE.
- Snooze cycle: snooze_btn in RING -> snoozing=1, snooze_left=3, snooze_count=1. Ticks step snooze_left 2,1. The third tick gives ringing=1 with a fresh 5-second timer. Repeat -> snooze_count=2. A third snooze_btn is ignored and ringing stays 1.
- Stop and no re-trigger: stop_btn in RING -> ringing=0 next cycle. With match held high for 10 ticks -> stays idle/DONE. A match 0->1 pulse then re-triggers.
- Disarm: alarm_en=0 during SNOOZE -> snoozing=0, snooze_left=0. A match edge with alarm_en=0 -> no ring.
- Reset and collisions:
  - match high at rst release -> no ring.
  - stop_btn and snooze_btn in the same cycle -> DONE, snooze_count unchanged.
  - Async rst asserted mid-RING between clk edges -> ringing=0 and alarm_led=0 immediately.
